isdu: RTL and testbench

ISDU -- requirements
Module: isdu

---
 rtl/lc3_pkg.sv | 69 ++++++
 rtl/isdu.sv | 232 +++++++++++++++++++++++
 tb/tb_isdu.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/lc3_pkg.sv
// ============================================================================
//  Module      : lc3_pkg
//  Description : Shared LC-3 definitions for the control unit and datapath:
//                opcode and controller state enumerations, plus the select
//                encodings for PCMUX, ADDR2MUX and ALUK.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lc3_pkg;

    // Opcodes (IR[15:12]) that the controller decodes
    typedef enum logic [3:0] {
        OP_BR  = 4'b0000,
        OP_ADD = 4'b0001,
        OP_JSR = 4'b0100,
        OP_AND = 4'b0101,
        OP_LDR = 4'b0110,
        OP_STR = 4'b0111,
        OP_NOT = 4'b1001,
        OP_JMP = 4'b1100,
        OP_PSE = 4'b1101
    } opcode_t;

    // Controller states
    typedef enum logic [4:0] {
        S_HALTED    = 5'd0,
        S_18        = 5'd1,
        S_33        = 5'd2,
        S_35        = 5'd3,
        S_32        = 5'd4,
        S_01        = 5'd5,
        S_05        = 5'd6,
        S_09        = 5'd7,
        S_00        = 5'd8,
        S_22        = 5'd9,
        S_12        = 5'd10,
        S_04        = 5'd11,
        S_21        = 5'd12,
        S_06        = 5'd13,
        S_25        = 5'd14,
        S_27        = 5'd15,
        S_07        = 5'd16,
        S_23        = 5'd17,
        S_16        = 5'd18,
        S_PAUSE_IR1 = 5'd19,
        S_PAUSE_IR2 = 5'd20
    } state_t;

    // PCMUX selects
    localparam logic [1:0] C_PCMUX_INC   = 2'd0;
    localparam logic [1:0] C_PCMUX_BUS   = 2'd1;
    localparam logic [1:0] C_PCMUX_ADDER = 2'd2;

    // ADDR2MUX selects
    localparam logic [1:0] C_ADDR2_ZERO  = 2'd0;
    localparam logic [1:0] C_ADDR2_OFF6  = 2'd1;
    localparam logic [1:0] C_ADDR2_OFF9  = 2'd2;
    localparam logic [1:0] C_ADDR2_OFF11 = 2'd3;

    // ALU operations
    localparam logic [1:0] C_ALUK_ADD    = 2'd0;
    localparam logic [1:0] C_ALUK_AND    = 2'd1;
    localparam logic [1:0] C_ALUK_NOT    = 2'd2;
    localparam logic [1:0] C_ALUK_PASSA  = 2'd3;

endpackage

`default_nettype wire

// File: rtl/isdu.sv
// ============================================================================
//  Module      : isdu
//  Description : LC-3 instruction sequencer / decoder. Moore FSM that walks
//                fetch, decode and execute for ADD/AND/NOT/BR/JMP/JSR/LDR/STR
//                and a two-state pause, with an inline wait counter that
//                stretches SRAM read/write states to MEM_WAIT cycles.
//  Ports       : Clk, Reset (async, active-low), Run, Continue,
//                Opcode/IR_5/IR_11/BEN (decode inputs),
//                LD_* register loads, Gate* bus drivers, mux selects,
//                ALUK, and active-low SRAM strobes Mem_*.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module isdu
    import lc3_pkg::*;
#(
    parameter int MEM_WAIT = 2
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Run,
    input  logic       Continue,
    input  logic [3:0] Opcode,
    input  logic       IR_5,
    input  logic       IR_11,
    input  logic       BEN,
    output logic       LD_MAR,
    output logic       LD_MDR,
    output logic       LD_IR,
    output logic       LD_BEN,
    output logic       LD_CC,
    output logic       LD_REG,
    output logic       LD_PC,
    output logic       LD_LED,
    output logic       GatePC,
    output logic       GateMDR,
    output logic       GateALU,
    output logic       GateMARMUX,
    output logic [1:0] PCMUX,
    output logic [1:0] ADDR2MUX,
    output logic       ADDR1MUX,
    output logic       DRMUX,
    output logic       SR1MUX,
    output logic       SR2MUX,
    output logic [1:0] ALUK,
    output logic       Mem_CE,
    output logic       Mem_UB,
    output logic       Mem_LB,
    output logic       Mem_OE,
    output logic       Mem_WE
);

    localparam logic [2:0] C_LAST = 3'(MEM_WAIT - 1);

    state_t     state;
    state_t     next_state;
    logic [2:0] wait_cnt;
    logic       led_done;   // set after the first cycle spent in PAUSE_IR1
    logic       wait_last;

    assign wait_last = (wait_cnt == C_LAST);

    // ------------------------------------------------------------------
    // State register, wait counter and pause-entry flag.
    // The counter is cleared on every state change, so each memory state
    // starts counting from 0, and it stops advancing on the last cycle
    // because that cycle always leaves the state.
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state    <= S_HALTED;
            wait_cnt <= 3'd0;
            led_done <= 1'b0;
        end else begin
            state <= next_state;
            if (next_state != state)
                wait_cnt <= 3'd0;
            else if (state == S_33 || state == S_25 || state == S_16)
                wait_cnt <= wait_cnt + 3'd1;
            led_done <= (state == S_PAUSE_IR1);
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        next_state = state;
        unique case (state)
            S_HALTED:    if (Run) next_state = S_18;
            S_18:        next_state = S_33;
            S_33:        if (wait_last) next_state = S_35;
            S_35:        next_state = S_32;
            S_32: begin
                case (Opcode)
                    OP_ADD:  next_state = S_01;
                    OP_AND:  next_state = S_05;
                    OP_NOT:  next_state = S_09;
                    OP_BR:   next_state = S_00;
                    OP_JMP:  next_state = S_12;
                    OP_JSR:  next_state = S_04;
                    OP_LDR:  next_state = S_06;
                    OP_STR:  next_state = S_07;
                    OP_PSE:  next_state = S_PAUSE_IR1;
                    default: next_state = S_18;   // unimplemented opcode: NOP
                endcase
            end
            S_01, S_05, S_09: next_state = S_18;
            S_00:        next_state = BEN ? S_22 : S_18;
            S_22:        next_state = S_18;
            S_12:        next_state = S_18;
            S_04:        next_state = S_21;
            S_21:        next_state = S_18;
            S_06:        next_state = S_25;
            S_25:        if (wait_last) next_state = S_27;
            S_27:        next_state = S_18;
            S_07:        next_state = S_23;
            S_23:        next_state = S_16;
            S_16:        if (wait_last) next_state = S_18;
            // Two pause states so one press of Continue resumes exactly once
            S_PAUSE_IR1: if (Continue) next_state = S_PAUSE_IR2;
            S_PAUSE_IR2: if (!Continue) next_state = S_18;
            default:     next_state = S_HALTED;
        endcase
    end

    // ------------------------------------------------------------------
    // Moore output decode
    // ------------------------------------------------------------------
    always_comb begin
        LD_MAR     = 1'b0;
        LD_MDR     = 1'b0;
        LD_IR      = 1'b0;
        LD_BEN     = 1'b0;
        LD_CC      = 1'b0;
        LD_REG     = 1'b0;
        LD_PC      = 1'b0;
        LD_LED     = 1'b0;
        GatePC     = 1'b0;
        GateMDR    = 1'b0;
        GateALU    = 1'b0;
        GateMARMUX = 1'b0;
        PCMUX      = C_PCMUX_INC;
        ADDR2MUX   = C_ADDR2_ZERO;
        ADDR1MUX   = 1'b0;
        DRMUX      = 1'b0;
        SR1MUX     = 1'b0;
        SR2MUX     = 1'b0;
        ALUK       = C_ALUK_ADD;
        Mem_CE     = 1'b0;
        Mem_UB     = 1'b0;
        Mem_LB     = 1'b0;
        Mem_OE     = 1'b1;
        Mem_WE     = 1'b1;
        unique case (state)
            S_18: begin
                GatePC = 1'b1;
                LD_MAR = 1'b1;
                PCMUX  = C_PCMUX_INC;
                LD_PC  = 1'b1;
            end
            S_33, S_25: begin
                Mem_OE = 1'b0;
                LD_MDR = wait_last;
            end
            S_35: begin
                GateMDR = 1'b1;
                LD_IR   = 1'b1;
            end
            S_32: LD_BEN = 1'b1;
            S_01, S_05, S_09: begin
                SR1MUX  = 1'b1;
                SR2MUX  = (state == S_09) ? 1'b0 : IR_5;
                ALUK    = (state == S_01) ? C_ALUK_ADD :
                          (state == S_05) ? C_ALUK_AND : C_ALUK_NOT;
                GateALU = 1'b1;
                LD_REG  = 1'b1;
                LD_CC   = 1'b1;
            end
            S_22: begin
                ADDR2MUX = C_ADDR2_OFF9;
                PCMUX    = C_PCMUX_ADDER;
                LD_PC    = 1'b1;
            end
            S_12: begin
                SR1MUX   = 1'b1;
                ADDR1MUX = 1'b1;
                PCMUX    = C_PCMUX_ADDER;
                LD_PC    = 1'b1;
            end
            S_04: begin
                GatePC = 1'b1;
                DRMUX  = 1'b1;
                LD_REG = 1'b1;
            end
            S_21: begin
                if (IR_11) begin
                    ADDR2MUX = C_ADDR2_OFF11;
                end else begin
                    ADDR1MUX = 1'b1;
                    SR1MUX   = 1'b1;
                end
                PCMUX = C_PCMUX_ADDER;
                LD_PC = 1'b1;
            end
            S_06, S_07: begin
                SR1MUX     = 1'b1;
                ADDR1MUX   = 1'b1;
                ADDR2MUX   = C_ADDR2_OFF6;
                GateMARMUX = 1'b1;
                LD_MAR     = 1'b1;
            end
            S_27: begin
                GateMDR = 1'b1;
                LD_REG  = 1'b1;
                LD_CC   = 1'b1;
            end
            S_23: begin
                ALUK    = C_ALUK_PASSA;
                GateALU = 1'b1;
                LD_MDR  = 1'b1;
            end
            S_16:        Mem_WE = 1'b0;
            S_PAUSE_IR1: LD_LED = !led_done;
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_isdu.sv
// ============================================================================
//  Module      : tb_isdu
//  Description : Directed self-checking bench for isdu (MEM_WAIT = 2).
//                Outputs are packed into one control word and compared
//                against hand-built expected words each cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_isdu;
    import lc3_pkg::*;

    logic       Clk = 1'b0;
    logic       Reset, Run, Continue, IR_5, IR_11, BEN;
    logic [3:0] Opcode;
    logic       LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED;
    logic       GatePC, GateMDR, GateALU, GateMARMUX;
    logic [1:0] PCMUX, ADDR2MUX, ALUK;
    logic       ADDR1MUX, DRMUX, SR1MUX, SR2MUX;
    logic       Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE;

    int checks   = 0;
    int failures = 0;

    isdu #(.MEM_WAIT(2)) dut (
        .Clk(Clk), .Reset(Reset), .Run(Run), .Continue(Continue),
        .Opcode(Opcode), .IR_5(IR_5), .IR_11(IR_11), .BEN(BEN),
        .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR), .LD_BEN(LD_BEN),
        .LD_CC(LD_CC), .LD_REG(LD_REG), .LD_PC(LD_PC), .LD_LED(LD_LED),
        .GatePC(GatePC), .GateMDR(GateMDR), .GateALU(GateALU),
        .GateMARMUX(GateMARMUX), .PCMUX(PCMUX), .ADDR2MUX(ADDR2MUX),
        .ADDR1MUX(ADDR1MUX), .DRMUX(DRMUX), .SR1MUX(SR1MUX), .SR2MUX(SR2MUX),
        .ALUK(ALUK), .Mem_CE(Mem_CE), .Mem_UB(Mem_UB), .Mem_LB(Mem_LB),
        .Mem_OE(Mem_OE), .Mem_WE(Mem_WE)
    );

    always #5 Clk = ~Clk;

    // Control word bit positions
    localparam logic [23:0] MAR   = 24'h1 << 23;
    localparam logic [23:0] MDR   = 24'h1 << 22;
    localparam logic [23:0] LIR   = 24'h1 << 21;
    localparam logic [23:0] LBEN  = 24'h1 << 20;
    localparam logic [23:0] LCC   = 24'h1 << 19;
    localparam logic [23:0] LREG  = 24'h1 << 18;
    localparam logic [23:0] LPC   = 24'h1 << 17;
    localparam logic [23:0] LLED  = 24'h1 << 16;
    localparam logic [23:0] GPC   = 24'h1 << 15;
    localparam logic [23:0] GMDR  = 24'h1 << 14;
    localparam logic [23:0] GALU  = 24'h1 << 13;
    localparam logic [23:0] GMM   = 24'h1 << 12;
    localparam logic [23:0] PCM2  = 24'h2 << 10;
    localparam logic [23:0] A2_1  = 24'h1 << 8;
    localparam logic [23:0] A2_2  = 24'h2 << 8;
    localparam logic [23:0] A1    = 24'h1 << 7;
    localparam logic [23:0] SR1   = 24'h1 << 5;
    localparam logic [23:0] SR2   = 24'h1 << 4;
    localparam logic [23:0] AK1   = 24'h1 << 2;
    localparam logic [23:0] AK3   = 24'h3 << 2;
    localparam logic [23:0] OE    = 24'h2;
    localparam logic [23:0] WE    = 24'h1;
    localparam logic [23:0] IDLE  = OE | WE;
    localparam logic [23:0] X_18  = IDLE | GPC | MAR | LPC;

    logic [23:0] ctrl;
    assign ctrl = {LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
                   GatePC, GateMDR, GateALU, GateMARMUX, PCMUX, ADDR2MUX,
                   ADDR1MUX, DRMUX, SR1MUX, SR2MUX, ALUK, Mem_OE, Mem_WE};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    // Starting in S_18, walk the fetch/decode states and end in S_32
    task automatic fetch(input string name);
        check({name, "_s18"}, 32'(ctrl), 32'(X_18));
        step(); check({name, "_s33a"}, 32'(ctrl), 32'(WE));
        step(); check({name, "_s33b"}, 32'(ctrl), 32'(WE | MDR));
        step(); check({name, "_s35"}, 32'(ctrl), 32'(IDLE | GMDR | LIR));
        step(); check({name, "_s32"}, 32'(ctrl), 32'(IDLE | LBEN));
    endtask

    initial begin
        Reset = 1'b0; Run = 1'b1; Continue = 1'b0;
        Opcode = 4'b0001; IR_5 = 1'b1; IR_11 = 1'b0; BEN = 1'b0;

        // Reset held with Run high: stays halted, all outputs idle
        step(); step();
        check("rst_state", 32'(dut.state), 32'(S_HALTED));
        check("rst_ctrl", 32'(ctrl), 32'(IDLE));
        check("rst_ce_ub_lb", 32'({Mem_CE, Mem_UB, Mem_LB}), 32'd0);

        // Release; first edge with Reset=1 starts the fetch
        Reset = 1'b1;
        step();
        Run = 1'b0;

        // ADD with immediate
        fetch("add");
        step(); check("add_s01", 32'(ctrl), 32'(IDLE | SR1 | SR2 | GALU | LREG | LCC));
        step();

        // AND register form
        Opcode = 4'b0101; IR_5 = 1'b0;
        fetch("and");
        step(); check("and_s05", 32'(ctrl), 32'(IDLE | SR1 | AK1 | GALU | LREG | LCC));
        step();

        // Unimplemented opcode behaves as NOP; a held Run changes nothing
        Opcode = 4'b0011; Run = 1'b1;
        fetch("nop");
        step(); check("nop_back18", 32'(ctrl), 32'(X_18));
        Run = 1'b0;

        // Branch not taken
        Opcode = 4'b0000; BEN = 1'b0;
        fetch("brn");
        step(); check("brn_s00", 32'(ctrl), 32'(IDLE));
        step();

        // Branch taken
        BEN = 1'b1;
        fetch("bry");
        step(); check("bry_s00", 32'(ctrl), 32'(IDLE));
        step(); check("bry_s22", 32'(ctrl), 32'(IDLE | A2_2 | PCM2 | LPC));
        step();

        // Pause: LED once, Continue held 10 cycles, one resume on release
        Opcode = 4'b1101;
        fetch("pse");
        step(); check("pse_led", 32'(ctrl), 32'(IDLE | LLED));
        step(); check("pse_wait", 32'(ctrl), 32'(IDLE));
        Continue = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(); check("pse_held", 32'(ctrl), 32'(IDLE));
        end
        Continue = 1'b0;
        step();

        // Store: address, data, then reset during the first write cycle
        Opcode = 4'b0111;
        fetch("str");
        step(); check("str_s07", 32'(ctrl), 32'(IDLE | SR1 | A1 | A2_1 | GMM | MAR));
        step(); check("str_s23", 32'(ctrl), 32'(IDLE | AK3 | GALU | MDR));
        step(); check("str_s16", 32'(ctrl), 32'(OE));
        #1 Reset = 1'b0;
        #1;
        check("str_rst_we", 32'(Mem_WE), 32'd1);
        check("str_rst_state", 32'(dut.state), 32'(S_HALTED));
        @(negedge Clk);
        Reset = 1'b1;
        step();
        check("post_rst_idle", 32'(ctrl), 32'(IDLE));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Safety net so the run always terminates
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
